// File: rtl/struct_bus_assembler.sv
// struct_bus_assembler: collects three consecutive WIDTH-bit beats into one
// packed {a, b, c} struct and hands it downstream over valid/ready. A beat
// flagged start-of-frame in the middle of a struct restarts assembly and
// raises a sticky sync error. Delivered structs are counted, with wrap.
module struct_bus_assembler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_sof,
  output logic               bus_valid,
  input  logic               bus_ready,
  output logic [3*WIDTH-1:0] bus,
  output logic               sync_err,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    FILL_C = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             deliver;
  logic             load_a;
  logic             load_b;
  logic             load_c;
  logic             set_err;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] c_p0;

  // Wrapping increment of the delivered-struct counter.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return cnt + one;
  endfunction

  // A beat is only refused while a finished struct waits for the consumer;
  // in HOLD a delivery frees the register in the same cycle, so the beat
  // arriving then is taken as the next field a without a bubble.
  assign in_ready  = (state != HOLD) | bus_ready;
  assign bus_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;
  assign deliver   = bus_valid & bus_ready;
  assign bus       = {a_p0, b_p0, c_p0};

  // Next-state and field-load decode.
  always_comb begin
    state_nxt = state;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    set_err   = 1'b0;
    case (state)
      FILL_A: begin
        if (accept) begin
          load_a    = 1'b1;
          state_nxt = FILL_B;
        end
      end
      FILL_B: begin
        if (accept) begin
          if (in_sof) begin
            // Start-of-frame mid-struct: drop the partial, restart with a.
            load_a    = 1'b1;
            set_err   = 1'b1;
            state_nxt = FILL_B;
          end else begin
            load_b    = 1'b1;
            state_nxt = FILL_C;
          end
        end
      end
      FILL_C: begin
        if (accept) begin
          if (in_sof) begin
            load_a    = 1'b1;
            set_err   = 1'b1;
            state_nxt = FILL_B;
          end else begin
            load_c    = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (deliver) begin
          if (accept) begin
            load_a    = 1'b1;
            state_nxt = FILL_B;
          end else begin
            state_nxt = FILL_A;
          end
        end
      end
      default: state_nxt = FILL_A;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL_A;
    else     state <= state_nxt;
  end

  // Field registers; cleared on reset so the bus reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0 <= '0;
      b_p0 <= '0;
      c_p0 <= '0;
    end else begin
      if (load_a) a_p0 <= in_data;
      if (load_b) b_p0 <= in_data;
      if (load_c) c_p0 <= in_data;
    end
  end

  // Delivered-struct counter.
  always_ff @(posedge clk) begin
    if (rst)          frame_cnt <= '0;
    else if (deliver) frame_cnt <= cnt_inc(frame_cnt);
  end

  // Sticky sync error; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)          sync_err <= 1'b0;
    else if (set_err) sync_err <= 1'b1;
  end

endmodule

// File: tb/tb_struct_bus_assembler.sv
// Bench for struct_bus_assembler: a WIDTH=8 instance driven from a table of
// per-cycle vectors, and a WIDTH=16/CNT_W=2 instance driven by a short
// hand-written sequence to exercise counter wrap.
module tb_struct_bus_assembler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance signals
  logic        rst8, v8, sof8, rdy8;
  logic [7:0]  d8;
  logic        irdy8, bv8, err8;
  logic [23:0] bus8;
  logic [15:0] cnt8;

  // WIDTH=16, CNT_W=2 instance signals
  logic        rst16, v16, sof16, rdy16;
  logic [15:0] d16;
  logic        irdy16, bv16, err16;
  logic [47:0] bus16;
  logic [1:0]  cnt16;

  struct_bus_assembler #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(v8), .in_ready(irdy8), .in_data(d8),
    .in_sof(sof8), .bus_valid(bv8), .bus_ready(rdy8), .bus(bus8),
    .sync_err(err8), .frame_cnt(cnt8)
  );

  struct_bus_assembler #(.WIDTH(16), .CNT_W(2)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(v16), .in_ready(irdy16), .in_data(d16),
    .in_sof(sof16), .bus_valid(bv16), .bus_ready(rdy16), .bus(bus16),
    .sync_err(err16), .frame_cnt(cnt16)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        sof;
    logic        rdy;
    logic        e_rdy;   // in_ready during the cycle
    logic        e_bv;    // bus_valid after the edge
    logic [23:0] e_bus;   // bus after the edge (when chkbus)
    logic        chkbus;
    logic        e_err;
    logic [15:0] e_cnt;
  } row_t;

  row_t rows[$];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] d,
                     input logic sof, input logic rdy, input logic erdy,
                     input logic ebv, input logic [23:0] ebus, input logic cb,
                     input logic eerr, input logic [15:0] ecnt);
    row_t x;
    x.rst = r; x.v = v; x.d = d; x.sof = sof; x.rdy = rdy; x.e_rdy = erdy;
    x.e_bv = ebv; x.e_bus = ebus; x.chkbus = cb; x.e_err = eerr; x.e_cnt = ecnt;
    rows.push_back(x);
  endtask

  logic [47:0] s16 [5];
  logic [1:0]  c16 [5];

  initial begin
    logic [7:0] bd;
    rst8 = 1'b1; v8 = 1'b0; d8 = '0; sof8 = 1'b0; rdy8 = 1'b1;
    rst16 = 1'b1; v16 = 1'b0; d16 = '0; sof16 = 1'b0; rdy16 = 1'b1;

    // Basic fill 11/22/33, then delivery
    add(0,1,8'h11,0,1, 1,0,24'h0,0,0,16'd0);
    add(0,1,8'h22,0,1, 1,0,24'h0,0,0,16'd0);
    add(0,1,8'h33,0,1, 1,1,24'h112233,1,0,16'd0);
    add(0,0,8'h00,0,1, 1,0,24'h0,0,0,16'd1);
    // Streaming: 12 beats back-to-back, structs on every third beat
    for (int i = 0; i < 12; i++) begin
      bd = 8'h41 + 8'(i);
      add(0,1,bd,0,1, 1,(i%3==2),{bd-8'd2,bd-8'd1,bd},(i%3==2),0,16'(1 + i/3));
    end
    add(0,0,8'h00,0,1, 1,0,24'h0,0,0,16'd5);
    // Backpressure: FF/F0/3C held 5 cycles while AA waits
    add(0,1,8'hFF,0,0, 1,0,24'h0,0,0,16'd5);
    add(0,1,8'hF0,0,0, 1,0,24'h0,0,0,16'd5);
    add(0,1,8'h3C,0,0, 1,1,24'hFFF03C,1,0,16'd5);
    for (int i = 0; i < 5; i++) add(0,1,8'hAA,0,0, 0,1,24'hFFF03C,1,0,16'd5);
    // Release: deliver and take AA (sof in HOLD is legal) in one cycle
    add(0,1,8'hAA,1,1, 1,0,24'hAAF03C,1,0,16'd6);
    add(0,1,8'hBB,0,1, 1,0,24'h0,0,0,16'd6);
    add(0,1,8'hCC,0,1, 1,1,24'hAABBCC,1,0,16'd6);
    add(0,0,8'h00,0,1, 1,0,24'h0,0,0,16'd7);
    // Resync: sof in FILL_A is legal, sof in FILL_C restarts and flags
    add(0,1,8'h01,1,1, 1,0,24'h0,0,0,16'd7);
    add(0,1,8'h02,0,1, 1,0,24'h0,0,0,16'd7);
    add(0,1,8'h10,1,1, 1,0,24'h1002CC,1,1,16'd7);
    add(0,1,8'h20,0,1, 1,0,24'h0,0,1,16'd7);
    add(0,1,8'h30,0,1, 1,1,24'h102030,1,1,16'd7);
    add(0,0,8'h00,0,1, 1,0,24'h0,0,1,16'd8);
    add(0,0,8'h00,0,0, 1,0,24'h0,0,1,16'd8);
    // Reset while holding: the pending delivery is dropped
    add(0,1,8'h91,0,0, 1,0,24'h0,0,1,16'd8);
    add(0,1,8'h92,0,0, 1,0,24'h0,0,1,16'd8);
    add(0,1,8'h93,0,0, 1,1,24'h919293,1,1,16'd8);
    add(0,1,8'h94,0,0, 0,1,24'h919293,1,1,16'd8);
    add(1,1,8'h95,0,1, 1,0,24'h000000,1,0,16'd0);
    // Reset mid-fill after a and b
    add(0,1,8'h55,0,1, 1,0,24'h0,0,0,16'd0);
    add(0,1,8'h66,0,1, 1,0,24'h0,0,0,16'd0);
    add(1,1,8'h77,0,1, 1,0,24'h000000,1,0,16'd0);
    add(0,1,8'h81,0,1, 1,0,24'h0,0,0,16'd0);
    add(0,1,8'h82,0,1, 1,0,24'h0,0,0,16'd0);
    add(0,1,8'h83,0,1, 1,1,24'h818283,1,0,16'd0);
    add(0,0,8'h00,0,1, 1,0,24'h0,0,0,16'd1);

    s16[0] = 48'hFFFF_0F0F_00FF; s16[1] = 48'h1234_5678_9ABC;
    s16[2] = 48'h0001_0002_0003; s16[3] = 48'hAAAA_5555_FFFF;
    s16[4] = 48'h8000_0001_7FFF;
    c16[0] = 2'd1; c16[1] = 2'd2; c16[2] = 2'd3; c16[3] = 2'd0; c16[4] = 2'd1;

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst8 = 1'b0; rst16 = 1'b0;
    #1;
    chk("rst_in_ready", irdy8, 1'b1);
    chk("rst_bus_valid", bv8, 1'b0);
    chk("rst_bus", bus8, 24'h0);
    chk("rst_sync_err", err8, 1'b0);
    chk("rst_frame_cnt", cnt8, 16'd0);
    chk("rst16_bus", bus16, 48'h0);
    chk("rst16_frame_cnt", cnt16, 2'd0);

    // Table-driven run on the 8-bit instance
    foreach (rows[i]) begin
      @(negedge clk);
      rst8 = rows[i].rst; v8 = rows[i].v; d8 = rows[i].d;
      sof8 = rows[i].sof; rdy8 = rows[i].rdy;
      #1;
      chk($sformatf("r%0d_in_ready", i), irdy8, rows[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("r%0d_bus_valid", i), bv8, rows[i].e_bv);
      if (rows[i].chkbus) chk($sformatf("r%0d_bus", i), bus8, rows[i].e_bus);
      chk($sformatf("r%0d_sync_err", i), err8, rows[i].e_err);
      chk($sformatf("r%0d_frame_cnt", i), cnt8, rows[i].e_cnt);
    end
    @(negedge clk);
    v8 = 1'b0; rst8 = 1'b0;

    // 16-bit instance: 5 structs, 2-bit counter wraps 1,2,3,0,1
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        v16 = 1'b1;
        d16 = s16[s][47 - 16*k -: 16];
        @(posedge clk);
      end
      #1;
      chk($sformatf("w16_s%0d_bus_valid", s), bv16, 1'b1);
      chk($sformatf("w16_s%0d_bus", s), bus16, s16[s]);
      @(negedge clk);
      v16 = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("w16_s%0d_frame_cnt", s), cnt16, c16[s]);
      chk($sformatf("w16_s%0d_sync_err", s), err16, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
